fft_frame_serializer: RTL and testbench
=======================================

FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

Interface
REQ-001 SHALL have parameter NBINS, default 16, meaning number of complex bins per frame (fixed at 16 for this release).
REQ-002 SHALL have parameter CW, default 16, meaning width of each real/imag component (signed, 8 integer + 8 fraction).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 fft_valid  input  1  one-cycle strobe: fft_d0..fft_d15 carry a complete frame.
REQ-006 fft_d0..fft_d15  input  32 each  bin k as {real[31:16], imag[15:0]}, two's complement.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 clr_ovf  input  1  synchronous clear of overflow and drop_cnt.
REQ-009 out_valid  output  1  out_data/out_idx/out_last valid.
REQ-010 out_data  output  32  current bin, same packing as fft_dN.
REQ-011 out_idx  output  4  bin index of out_data.
REQ-012 out_last  output  1  high with bin 15.
REQ-013 peak_valid  output  1  one-cycle pulse: peak result of the frame just streamed.
REQ-014 peak_idx  output  4  bin index with largest re^2+im^2.
REQ-015 peak_mag  output  33  unsigned re^2+im^2 of peak_idx.
REQ-016 overflow  output  1  sticky: at least one frame dropped.
REQ-017 drop_cnt  output  8  dropped-frame count, saturating at 255.

Function
REQ-018 Two-bank frame buffer (ping-pong); each bank holds 16 x 32 bits plus a full flag.
REQ-019 On fft_valid with a free bank, all 16 inputs SHALL be captured into the write bank at that edge; write pointer toggles.
REQ-020 out_valid SHALL rise the cycle after capture when no frame was streaming (1-cycle latency).
REQ-021 Bins SHALL stream in order 0..15, one per handshake (out_valid & out_ready); out_idx increments on handshake only.
REQ-022 While out_valid & !out_ready, out_data/out_idx/out_last SHALL hold stable; out_valid SHALL not drop until handshake.
REQ-023 After the bin-15 handshake, the read bank is freed; if the other bank is full, bin 0 of it is presented the next cycle (no bubble required but at most one allowed).
REQ-024 fft_valid arriving in the same cycle as the bin-15 handshake with both banks full SHALL be accepted into the bank being freed.
REQ-025 fft_valid with both banks full (and no freeing handshake) SHALL drop the frame, set overflow, increment drop_cnt (saturating); buffered frames unaffected.
REQ-026 Magnitude per bin = re*re + im*im, signed 16x16 products, summed into 33-bit unsigned, computed on each handshake.
REQ-027 Running max SHALL use strict greater-than, so the lowest index wins on tie; bin 0 initializes the max.
REQ-028 peak_valid SHALL pulse exactly one cycle, the cycle after the bin-15 handshake; peak_idx/peak_mag hold until next pulse.
REQ-029 clr_ovf SHALL clear overflow and drop_cnt; if coincident with a drop, the clear wins and the drop is not counted.

Reset
REQ-030 While rst low: out_valid, out_last, peak_valid, overflow = 0; out_data, out_idx, peak_idx, peak_mag, drop_cnt = 0; both banks empty; pointers 0.
REQ-031 Reset mid-frame SHALL discard all buffered and partially streamed frames; first fft_valid after release starts bank 0.

Structure
REQ-032 Shared package fas_pkg SHALL hold NBINS, CW, the bin packing (real high / imag low) and the magnitude width (2*CW+1).
REQ-033 One sub-module, fft_mag_sq (combinational re^2+im^2), SHALL be instantiated once on the read path.

Verification
REQ-034 Single frame, bin k = {k, -k}, out_ready=1 -> 16 beats idx 0..15 starting 1 cycle after fft_valid, out_last on beat 15, peak_idx=15, peak_mag=450.
REQ-035 Same frame, out_ready toggled 1010... -> identical beat sequence, data stable during stalls, peak pulse after 16th handshake.
REQ-036 Three fft_valid strobes 1 cycle apart, out_ready=0 -> frames 1,2 held, frame 3 dropped, overflow=1, drop_cnt=1; releasing out_ready streams frames 1 then 2.
REQ-037 All bins {0x0100,0x0000} except bins 3 and 9 = {0x0000,0x0200} -> peak_idx=3, peak_mag=0x40000.
REQ-038 rst asserted at beat 7 of a stream with second bank full -> all outputs zero; after release no beats until a new fft_valid.
REQ-039 Both banks full, fft_valid coincident with bin-15 handshake -> frame accepted, drop_cnt unchanged.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared constants and bin packing helpers for the FFT frame serializer.
// A bin is packed as {real, imag}, each a signed Q8.8 component.
package fas_pkg;
  localparam int NBINS = 16;
  localparam int CW    = 16;
  localparam int DW    = 2 * CW;
  localparam int MW    = 2 * CW + 1;

  function automatic logic signed [CW-1:0] bin_re(input logic [DW-1:0] bin);
    return bin[DW-1:CW];
  endfunction

  function automatic logic signed [CW-1:0] bin_im(input logic [DW-1:0] bin);
    return bin[CW-1:0];
  endfunction
endpackage

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one packed bin.
module fft_mag_sq
  import fas_pkg::*;
(
  input  logic [DW-1:0] bin_i,
  output logic [MW-1:0] mag_o
);
  logic signed [CW-1:0] re_s;
  logic signed [CW-1:0] im_s;
  logic signed [DW-1:0] re_sq_s;
  logic signed [DW-1:0] im_sq_s;

  assign re_s    = bin_re(bin_i);
  assign im_s    = bin_im(bin_i);
  assign re_sq_s = re_s * re_s;
  assign im_sq_s = im_s * im_s;
  // Each square is at most 2^30, so the 33-bit sum cannot wrap.
  assign mag_o   = {1'b0, re_sq_s} + {1'b0, im_sq_s};
endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong buffers whole FFT frames and streams them bin by bin with
// ready/valid, reporting the peak-magnitude bin of every streamed frame.
module fft_frame_serializer #(
  parameter int NBINS = fas_pkg::NBINS,
  parameter int CW    = fas_pkg::CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*CW-1:0] fft_d0,
  input  logic [2*CW-1:0] fft_d1,
  input  logic [2*CW-1:0] fft_d2,
  input  logic [2*CW-1:0] fft_d3,
  input  logic [2*CW-1:0] fft_d4,
  input  logic [2*CW-1:0] fft_d5,
  input  logic [2*CW-1:0] fft_d6,
  input  logic [2*CW-1:0] fft_d7,
  input  logic [2*CW-1:0] fft_d8,
  input  logic [2*CW-1:0] fft_d9,
  input  logic [2*CW-1:0] fft_d10,
  input  logic [2*CW-1:0] fft_d11,
  input  logic [2*CW-1:0] fft_d12,
  input  logic [2*CW-1:0] fft_d13,
  input  logic [2*CW-1:0] fft_d14,
  input  logic [2*CW-1:0] fft_d15,
  input  logic            out_ready,
  input  logic            clr_ovf,
  output logic            out_valid,
  output logic [2*CW-1:0] out_data,
  output logic [3:0]      out_idx,
  output logic            out_last,
  output logic            peak_valid,
  output logic [3:0]      peak_idx,
  output logic [2*CW:0]   peak_mag,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);
  import fas_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NBINS - 1);

  logic [2*CW-1:0] fft_in_s [NBINS];
  logic [2*CW-1:0] bank_q [2][NBINS];
  logic [2*CW-1:0] bank_d [2][NBINS];
  logic [1:0]      full_q, full_d, full_after_s;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [3:0]      out_idx_q, out_idx_d, nxt_idx_s;
  logic [2*CW-1:0] out_data_q, out_data_d;
  logic [2*CW:0]   mag_s, cand_mag_s, max_mag_q, max_mag_d;
  logic [3:0]      cand_idx_s, max_idx_q, max_idx_d;
  logic            peak_valid_q, peak_valid_d;
  logic [3:0]      peak_idx_q, peak_idx_d;
  logic [2*CW:0]   peak_mag_q, peak_mag_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            hs_s, hs_last_s, accept_s, drop_s, take_max_s;

  assign fft_in_s[0]  = fft_d0;
  assign fft_in_s[1]  = fft_d1;
  assign fft_in_s[2]  = fft_d2;
  assign fft_in_s[3]  = fft_d3;
  assign fft_in_s[4]  = fft_d4;
  assign fft_in_s[5]  = fft_d5;
  assign fft_in_s[6]  = fft_d6;
  assign fft_in_s[7]  = fft_d7;
  assign fft_in_s[8]  = fft_d8;
  assign fft_in_s[9]  = fft_d9;
  assign fft_in_s[10] = fft_d10;
  assign fft_in_s[11] = fft_d11;
  assign fft_in_s[12] = fft_d12;
  assign fft_in_s[13] = fft_d13;
  assign fft_in_s[14] = fft_d14;
  assign fft_in_s[15] = fft_d15;

  fft_mag_sq u_mag (
    .bin_i (out_data_q),
    .mag_o (mag_s)
  );

  // Handshake, bank-availability and running-max candidate decode.
  always_comb begin
    hs_s         = out_valid_q & out_ready;
    hs_last_s    = hs_s & out_last_q;
    full_after_s = full_q;
    if (hs_last_s) begin
      full_after_s[rd_ptr_q] = 1'b0;
    end else begin
      full_after_s = full_q;
    end
    // A bank freed by the final handshake is reusable in the same cycle.
    accept_s   = fft_valid & ~full_after_s[wr_ptr_q];
    drop_s     = fft_valid &  full_after_s[wr_ptr_q];
    nxt_idx_s  = out_idx_q + 4'd1;
    take_max_s = (out_idx_q == 4'd0) || (mag_s > max_mag_q);
    cand_mag_s = take_max_s ? mag_s : max_mag_q;
    cand_idx_s = take_max_s ? out_idx_q : max_idx_q;
  end

  // Next-state for buffers, output stream, peak tracking and drop accounting.
  always_comb begin
    bank_d       = bank_q;
    full_d       = full_after_s;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_idx_d    = out_idx_q;
    out_data_d   = out_data_q;
    max_mag_d    = max_mag_q;
    max_idx_d    = max_idx_q;
    peak_valid_d = hs_last_s;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;

    if (accept_s) begin
      bank_d[wr_ptr_q]   = fft_in_s;
      full_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d           = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (hs_s && !out_last_q) begin
      out_idx_d  = nxt_idx_s;
      out_data_d = bank_q[rd_ptr_q][nxt_idx_s];
      out_last_d = (nxt_idx_s == LAST_IDX);
    end else if (hs_last_s) begin
      rd_ptr_d   = ~rd_ptr_q;
      out_idx_d  = 4'd0;
      out_last_d = 1'b0;
      if (full_q[~rd_ptr_q]) begin
        out_valid_d = 1'b1;
        out_data_d  = bank_q[~rd_ptr_q][4'd0];
      end else if (accept_s) begin
        out_valid_d = 1'b1;
        out_data_d  = fft_in_s[0];
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    end else if (!out_valid_q && accept_s) begin
      // Idle: present bin 0 straight from the inputs for one-cycle latency.
      out_valid_d = 1'b1;
      out_idx_d   = 4'd0;
      out_last_d  = 1'b0;
      out_data_d  = fft_in_s[0];
    end else begin
      out_valid_d = out_valid_q;
    end

    if (hs_s) begin
      max_mag_d = cand_mag_s;
      max_idx_d = cand_idx_s;
    end else begin
      max_mag_d = max_mag_q;
    end

    if (hs_last_s) begin
      peak_idx_d = cand_idx_s;
      peak_mag_d = cand_mag_s;
    end else begin
      peak_idx_d = peak_idx_q;
    end

    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NBINS; k++) begin
          bank_q[b][k] <= '0;
        end
      end
      full_q       <= 2'b00;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_idx_q    <= 4'd0;
      out_data_q   <= '0;
      max_mag_q    <= '0;
      max_idx_q    <= 4'd0;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= 4'd0;
      peak_mag_q   <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      bank_q       <= bank_d;
      full_q       <= full_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_idx_q    <= out_idx_d;
      out_data_q   <= out_data_d;
      max_mag_q    <= max_mag_d;
      max_idx_q    <= max_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign peak_valid = peak_valid_q;
  assign peak_idx   = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed self-checking bench for fft_frame_serializer.
module tb_fft_frame_serializer;
  logic        clk = 1'b0;
  logic        rst, fft_valid, out_ready, clr_ovf;
  logic [31:0] fd [16];
  logic [31:0] ea [16];
  logic        out_valid, out_last, peak_valid, overflow;
  logic [31:0] out_data;
  logic [3:0]  out_idx, peak_idx;
  logic [32:0] peak_mag;
  logic [7:0]  drop_cnt;
  int          n_assert = 0;
  int          n_fail = 0;
  int          hs, cyc, beats, seen;
  logic [31:0] exp_d;

  fft_frame_serializer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_mag(peak_mag),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ramp(input logic [31:0] base);
    for (int k = 0; k < 16; k++) fd[k] = base + 32'(k);
  endtask

  initial begin
    rst = 1'b0; fft_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    ramp(32'h0);
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_peak", 64'({peak_valid, peak_idx, peak_mag}), 64'd0);
    chk("rst_ovf", 64'({overflow, drop_cnt}), 64'd0);
    rst = 1'b1;
    tick();

    // Single frame bin k = {k,-k}, always ready
    for (int k = 0; k < 16; k++) begin
      ea[k] = {16'(k), 16'(-k)};
      fd[k] = ea[k];
    end
    fft_valid = 1'b1; out_ready = 1'b1;
    tick();
    fft_valid = 1'b0;
    ramp(32'hDEAD_0000);
    for (int b = 0; b < 16; b++) begin
      chk("A_valid", 64'(out_valid), 64'd1);
      chk("A_idx", 64'(out_idx), 64'(b));
      chk("A_data", 64'(out_data), 64'(ea[b]));
      chk("A_last", 64'(out_last), 64'(b == 15));
      chk("A_no_peak", 64'(peak_valid), 64'd0);
      tick();
    end
    chk("A_peak_valid", 64'(peak_valid), 64'd1);
    chk("A_peak_idx", 64'(peak_idx), 64'd15);
    chk("A_peak_mag", 64'(peak_mag), 64'd450);
    chk("A_idle", 64'(out_valid), 64'd0);
    tick();
    chk("A_peak_pulse", 64'(peak_valid), 64'd0);
    chk("A_peak_hold", 64'(peak_idx), 64'd15);

    // Same frame with out_ready toggling 1010...
    for (int k = 0; k < 16; k++) fd[k] = ea[k];
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    ramp(32'hBEEF_0000);
    hs = 0; cyc = 0;
    while (hs < 16 && cyc < 64) begin
      out_ready = ((cyc % 2) == 0);
      chk("B_valid", 64'(out_valid), 64'd1);
      chk("B_idx", 64'(out_idx), 64'(hs));
      chk("B_data", 64'(out_data), 64'(ea[hs]));
      chk("B_no_peak", 64'(peak_valid), 64'd0);
      if (out_ready) hs++;
      tick();
      cyc++;
    end
    chk("B_hs_count", 64'(hs), 64'd16);
    chk("B_peak_valid", 64'(peak_valid), 64'd1);
    chk("B_peak", 64'({peak_idx, peak_mag}), {27'd0, 4'd15, 33'd450});

    // Three consecutive strobes with no ready: third frame dropped
    out_ready = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      ramp(32'(f) << 28);
      fft_valid = 1'b1;
      tick();
    end
    fft_valid = 1'b0;
    chk("C_overflow", 64'(overflow), 64'd1);
    chk("C_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("C_hold_valid", 64'(out_valid), 64'd1);
    chk("C_hold_data", 64'(out_data), 64'h1000_0000);
    out_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 32 && cyc < 40) begin
      if (out_valid) begin
        exp_d = ((beats < 16) ? 32'h1000_0000 : 32'h2000_0000) + 32'(beats % 16);
        chk("C_data", 64'(out_data), 64'(exp_d));
        chk("C_idx", 64'(out_idx), 64'(beats % 16));
        beats++;
      end
      tick();
      cyc++;
    end
    chk("C_beats", 64'(beats), 64'd32);
    repeat (3) tick();
    chk("C_frame3_gone", 64'(out_valid), 64'd0);
    chk("C_peak", 64'({peak_idx, peak_mag}), {27'd0, 4'd15, 33'h400_00E1});
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("C_clr", 64'({overflow, drop_cnt}), 64'd0);

    // Tie between bins 3 and 9: lowest index wins
    for (int k = 0; k < 16; k++) fd[k] = 32'h0100_0000;
    fd[3] = 32'h0000_0200;
    fd[9] = 32'h0000_0200;
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    repeat (16) tick();
    chk("D_peak_valid", 64'(peak_valid), 64'd1);
    chk("D_peak_idx", 64'(peak_idx), 64'd3);
    chk("D_peak_mag", 64'(peak_mag), 64'h4_0000);

    // Both banks full: drop, clear-wins, then accept on bin-15 handshake
    out_ready = 1'b0;
    ramp(32'h1000_0000); fft_valid = 1'b1; tick();
    ramp(32'h2000_0000); tick();
    ramp(32'h5000_0000); tick();
    chk("E_drop", 64'({overflow, drop_cnt}), {55'd0, 1'b1, 8'd1});
    clr_ovf = 1'b1;
    tick();
    fft_valid = 1'b0; clr_ovf = 1'b0;
    chk("E_clr_wins", 64'({overflow, drop_cnt}), 64'd0);
    out_ready = 1'b1;
    repeat (15) tick();
    chk("E_at_last", 64'({out_valid, out_last, out_idx}), 64'h3F);
    ramp(32'h3000_0000);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    chk("E_no_drop", 64'({overflow, drop_cnt}), 64'd0);
    chk("E_next_frame", 64'(out_data), 64'h2000_0000);
    beats = 0; cyc = 0;
    while (beats < 32 && cyc < 40) begin
      if (out_valid) begin
        exp_d = ((beats < 16) ? 32'h2000_0000 : 32'h3000_0000) + 32'(beats % 16);
        chk("E_data", 64'(out_data), 64'(exp_d));
        beats++;
      end
      tick();
      cyc++;
    end
    chk("E_beats", 64'(beats), 64'd32);
    tick();
    chk("E_idle", 64'(out_valid), 64'd0);

    // Reset at beat 7 with second bank full
    out_ready = 1'b0;
    ramp(32'h6000_0000); fft_valid = 1'b1; tick();
    ramp(32'h7000_0000); tick();
    ramp(32'h7700_0000); tick();
    fft_valid = 1'b0;
    out_ready = 1'b1;
    repeat (7) tick();
    chk("F_beat7", 64'({overflow, out_idx}), 64'h17);
    rst = 1'b0;
    #1;
    chk("F_rst_stream", 64'({out_valid, out_last, out_idx}), 64'd0);
    chk("F_rst_data", 64'(out_data), 64'd0);
    chk("F_rst_peak", 64'({peak_valid, peak_idx, peak_mag}), 64'd0);
    chk("F_rst_ovf", 64'({overflow, drop_cnt}), 64'd0);
    tick();
    rst = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    chk("F_no_beats", 64'(seen), 64'd0);
    ramp(32'h8000_0000);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    chk("F_restart", 64'({out_valid, out_idx, out_data}), {27'd0, 1'b1, 4'd0, 32'h8000_0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
